dma_write_engine: RTL
=====================

// Module: dma_write_engine
// PURPOSE
//  Drain side of the DMA data FIFO. Pops 32-bit words from sync_fifo and writes
//  them to consecutive destination addresses as single-beat AXI4-Lite writes.
//  Sits between the FIFO read port and the DMA's AXI4-Lite master AW/W/B channels.
//  It is started by the DMA control logic with a destination address and a word count.
// PARAMETERS
//  ADDR_W  32  AXI address width (byte address)
//  LEN_W   16  width of word_count
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  reset          in   1       asynchronous, active-high reset
//  start          in   1       start pulse; sampled only in IDLE
//  dst_addr       in   ADDR_W  destination byte address, word aligned; latched on start
//  word_count     in   LEN_W   number of 32-bit words to move; latched on start
//  busy           out  1       high from the cycle after start until done
//  done           out  1       one-cycle completion pulse
//  error          out  1       sticky SLVERR/DECERR flag; cleared by the next accepted start
//  fifo_rd_en     out  1       to FIFO_RD_EN; one-cycle pulse per word
//  fifo_read_data in   32      from FIFO read_data; valid the cycle after fifo_rd_en
//  fifo_empty     in   1       from FIFO_EMPTY
//  m_axi_awaddr   out  ADDR_W  write address, held stable while awvalid is high
//  m_axi_awprot   out  3       constant 3'b000
//  m_axi_awvalid  out  1       write address valid
//  m_axi_awready  in   1       write address ready
//  m_axi_wdata    out  32      write data, held stable while wvalid is high
//  m_axi_wstrb    out  4       constant 4'hF
//  m_axi_wvalid   out  1       write data valid
//  m_axi_wready   in   1       write data ready
//  m_axi_bresp    in   2       write response
//  m_axi_bvalid   in   1       write response valid
//  m_axi_bready   out  1       write response ready
// BEHAVIOUR
//  Reset: all outputs are 0 and the FSM is in IDLE.
//   Reset acts immediately and asynchronously, including mid-transfer.
//   Any in-flight AXI beat is abandoned; the slave must be reset together with this block.
//  FSM states: IDLE, POP, WAIT_DATA, XFER, RESP, DONE.
//  IDLE: on start, latch dst_addr, word_count and clear error.
//   - word_count==0: go to DONE with no FIFO or AXI activity.
//   - otherwise: go to POP and set busy=1.
//  start is ignored in every state other than IDLE.
//  POP: if !fifo_empty, drive fifo_rd_en=1 for exactly one cycle and go to WAIT_DATA.
//   Otherwise stay in POP with fifo_rd_en=0. Waiting has no timeout.
//  WAIT_DATA: capture fifo_read_data into the wdata register.
//   Next state XFER; awvalid and wvalid both rise together on entry.
//  XFER: AW and W handshakes complete independently.
//   - Each valid drops in the cycle after its own valid&&ready.
//   - The other valid stays high until its own handshake.
//   - Both handshakes in the same cycle is legal.
//   - After both have completed, go to RESP.
//   - valid never depends on ready, and address/data never change while valid is high.
//  RESP: bready=1 until bvalid.
//   - bresp!=2'b00: set error and go to DONE. The transfer aborts and no further pops occur.
//   - bresp==2'b00: remaining-=1 and addr+=4 (modulo 2^ADDR_W, wraps silently).
//     Then go to DONE if remaining==0, else go to POP.
//  DONE: done=1 for one cycle and busy falls in the same cycle; next state IDLE.
//  Ordering: word n is written to dst_addr+4n, in FIFO pop order. One beat is outstanding at most.
//  Best case is 5 cycles per word (POP, WAIT_DATA, XFER, RESP, plus one B cycle), with zero-wait slave and non-empty FIFO.
// TESTING
//  1. start with word_count=0 -> done pulses 1 cycle later; no fifo_rd_en or awvalid; busy stays 0.
//  2. FIFO holds A0..A3, dst=0x1000, count=4, readies held 1
//     -> writes 0x1000=A0, 0x1004=A1, 0x1008=A2, 0x100C=A3.
//     -> exactly 4 fifo_rd_en pulses, one done pulse, error=0.
//  3. wready=1 but awready delayed 3 cycles
//     -> wvalid drops after 1 cycle; awvalid holds 3 cycles with awaddr stable; RESP entered only after AW completes.
//  4. FIFO empty for 10 cycles after start, then 1 word is pushed, count=1
//     -> fifo_rd_en stays 0 while empty; a single write follows; done.
//  5. count=4, bresp=2'b10 on the 2nd beat
//     -> error=1, done pulses, only 2 pops and 2 AW beats; error clears on the next start.
//  6. Assert reset during XFER with awvalid=1
//     -> awvalid, wvalid, busy and fifo_rd_en go 0 immediately; a later start runs a clean transfer.
//     Also check dst=0xFFFFFFFC, count=2 -> 2nd address is 0x00000000.

Source files
------------

// File: rtl/dma_write_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_write_engine_if
// Description : Control, FIFO read-port and AXI4-Lite write-channel bundle
//               for the DMA write engine. The master modport is the engine
//               side; the slave modport is the controller/FIFO/AXI side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_write_engine_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  // Control from the DMA sequencer
  logic              start;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic              error;

  // FIFO read port
  logic              fifo_rd_en;
  logic [31:0]       fifo_read_data;
  logic              fifo_empty;

  // AXI4-Lite write address channel
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready;

  // AXI4-Lite write data channel
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;

  // AXI4-Lite write response channel
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  modport master (
    input  start, dst_addr, word_count,
    output busy, done, error,
    output fifo_rd_en,
    input  fifo_read_data, fifo_empty,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output start, dst_addr, word_count,
    input  busy, done, error,
    input  fifo_rd_en,
    output fifo_read_data, fifo_empty,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface
`default_nettype wire

// File: rtl/dma_write_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_write_engine
// Description : Drains 32-bit words from the DMA data FIFO and writes them to
//               consecutive destination addresses as single-beat AXI4-Lite
//               writes, one beat outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_write_engine #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  dma_write_engine_if.master bus
);

  localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  c_ONE       = LEN_W'(1);
  localparam logic [1:0]        c_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_XFER      = 3'd3,
    S_RESP      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_aw_done;
  logic              r_w_done;

  logic              w_pop;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_complete;
  logic              w_w_complete;
  logic              w_b_hs;
  logic              w_last;

  // The pop strobe is decoded from the registered state so that read data is
  // valid in WAIT_DATA, one cycle after the strobe, matching the FIFO latency.
  assign w_pop         = (r_state == S_POP) && !bus.fifo_empty;
  assign w_aw_hs       = r_awvalid && bus.m_axi_awready;
  assign w_w_hs        = r_wvalid && bus.m_axi_wready;
  assign w_aw_complete = r_aw_done || w_aw_hs;
  assign w_w_complete  = r_w_done || w_w_hs;
  assign w_b_hs        = r_bready && bus.m_axi_bvalid;
  assign w_last        = (r_remaining == c_ONE);

  // Transfer sequencer: one FIFO word per AXI beat, registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr      <= bus.dst_addr;
            r_remaining <= bus.word_count;
            r_error     <= 1'b0;
            if (bus.word_count == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_POP;
            end
          end
        end

        S_POP: begin
          if (!bus.fifo_empty) begin
            r_state <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          r_wdata   <= bus.fifo_read_data;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_state   <= S_XFER;
        end

        S_XFER: begin
          // Each channel retires on its own handshake; the response phase
          // starts only once both address and data have been accepted.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_complete && w_w_complete) begin
            r_bready <= 1'b1;
            r_state  <= S_RESP;
          end
        end

        S_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (bus.m_axi_bresp != c_RESP_OKAY) begin
              // Slave or decode error aborts the remainder of the job.
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_remaining <= r_remaining - c_ONE;
              r_addr      <= r_addr + c_ADDR_STEP;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_POP;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.fifo_rd_en    = w_pop;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = 4'hF;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;

endmodule
`default_nettype wire
